// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a-b one bit per clock, LSB first,
// reporting the modular difference, the unsigned borrow and the signed overflow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             bin_reg, bin_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_reg, borrow_next;
    logic             ovf_reg, ovf_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             d_bit, bout_bit;

    // Full subtractor on the current low bits of the operand shift registers.
    assign d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ bin_reg;
    assign bout_bit = (~a_sh_reg[0] & b_sh_reg[0]) | (~a_sh_reg[0] & bin_reg)
                    | (b_sh_reg[0] & bin_reg);

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_next    = res_reg;
        cnt_next    = cnt_reg;
        bin_next    = bin_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    bin_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_next = a_sh_reg >> 1;
                b_sh_next = b_sh_reg >> 1;
                res_next  = {d_bit, res_reg[WIDTH-1:1]};
                bin_next  = bout_bit;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    // On the last bit the shift registers' low bits are the operand sign bits.
                    diff_next   = {d_bit, res_reg[WIDTH-1:1]};
                    borrow_next = bout_bit;
                    ovf_next    = (a_sh_reg[0] != b_sh_reg[0]) && (d_bit != a_sh_reg[0]);
                    done_next   = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            cnt_reg    <= '0;
            bin_reg    <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_reg    <= res_next;
            cnt_reg    <= cnt_next;
            bin_reg    <= bin_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;
    assign ovf    = ovf_reg;
endmodule
